// File: rtl/ahb_line_fill_ctrl.sv
// ahb_line_fill_ctrl
//   Instruction-cache miss line-fill controller acting as an AHB read master.
//   A miss issues one aligned INCRn read burst covering the whole line; every
//   returned word is streamed to the line buffer with its word index. The
//   controller handles the AHB address/data pipeline, wait states and
//   two-cycle ERROR responses.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   miss_req   start a fill (sampled only while idle)
//   miss_addr  miss address; offset bits inside the line are ignored
//   fill_busy  high from miss acceptance through the fill_done cycle
//   fill_we    line-buffer write strobe, one per good data beat
//   fill_idx   word index for fill_we
//   fill_data  word for fill_we (hrdata pass-through)
//   fill_done  one-cycle pulse at the end of a fill
//   fill_err   one-cycle pulse with fill_done when any beat got ERROR
//   haddr, htrans, hburst, hsize, hwrite   AHB master address/control
//   hready, hrdata, hresp                  AHB slave response
module ahb_line_fill_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req,
  input  logic [ADDR_W-1:0]             miss_addr,
  output logic                          fill_busy,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          fill_done,
  output logic                          fill_err,
  output logic [ADDR_W-1:0]             haddr,
  output logic [1:0]                    htrans,
  output logic [2:0]                    hburst,
  output logic [2:0]                    hsize,
  output logic                          hwrite,
  input  logic                          hready,
  input  logic [DATA_W-1:0]             hrdata,
  input  logic                          hresp
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;  // byte offset bits inside a line

  localparam logic [2:0] HBURST_CODE = (LINE_WORDS == 4)  ? 3'b011 :
                                       (LINE_WORDS == 8)  ? 3'b101 :
                                       (LINE_WORDS == 16) ? 3'b111 : 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN,
    S_ERR,
    S_DONE
  } state_t;

  state_t                    state;
  logic [ADDR_W-OFF_W-1:0]   base_line;  // line number of the fill
  logic [IDX_W-1:0]          acnt;       // next beat to put on the address bus
  logic [IDX_W-1:0]          dcnt;       // next beat expected on the data bus
  logic                      dph;        // a beat is in its data phase
  logic                      err_flag;
  logic                      err_cycle;
  logic                      last_addr;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

  // First cycle of a two-cycle ERROR response on the beat in its data phase.
  assign err_cycle = dph & hresp & ~hready;
  assign last_addr = (acnt == IDX_W'(LINE_WORDS - 1));

  // The base is line aligned and acnt never passes the last word, so the
  // address is a plain concatenation and can never leave the line.
  assign haddr  = {base_line, acnt, 2'b00};
  assign hburst = HBURST_CODE;
  assign hsize  = 3'b010;
  assign hwrite = 1'b0;

  // htrans is combinational so the pending SEQ is withdrawn in the very
  // cycle the ERROR response first shows up.
  always_comb begin
    // NOTE: assigning a default before any condition keeps this a pure mux;
    // a path that left htrans unassigned would infer a latch.
    htrans = 2'b00;
    if (state == S_BURST && !err_cycle) begin
      htrans = (acnt == '0) ? 2'b10 : 2'b11;
    end
  end

  assign fill_we   = dph & hready & ~hresp & (state != S_ERR);
  assign fill_idx  = dcnt;
  assign fill_data = hrdata;

  // Status outputs decode straight from the state register.
  assign fill_busy = (state != S_IDLE);
  assign fill_done = (state == S_DONE);
  assign fill_err  = (state == S_DONE) & err_flag;

  // NOTE: the reset branch is asynchronous, so an asserted rst drops htrans
  // and fill_busy immediately; a partial fill is simply abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      base_line <= '0;
      acnt      <= '0;
      dcnt      <= '0;
      dph       <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch sees
      // this cycle's register values regardless of statement order.
      if (fill_we) begin
        dcnt <= dcnt + IDX_W'(1);
      end

      // A data phase starts after an accepted address phase and ends on the
      // next hready; back-to-back beats keep it continuously set.
      if (htrans[1] && hready) begin
        dph <= 1'b1;
      end else if (hready) begin
        dph <= 1'b0;
      end

      // Any ERROR seen on a data beat marks the whole line bad.
      if ((state == S_BURST || state == S_DRAIN) && dph && hresp) begin
        err_flag <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (miss_req) begin
            base_line <= miss_addr[ADDR_W-1:OFF_W];
            acnt      <= '0;
            dcnt      <= '0;
            err_flag  <= 1'b0;
            state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (err_cycle) begin
            state <= S_ERR;
          end else if (hready) begin
            if (last_addr) begin
              state <= S_DRAIN;
            end else begin
              acnt <= acnt + IDX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          // The last beat is always in its data phase here.
          if (err_cycle) begin
            state <= S_ERR;
          end else if (hready) begin
            state <= S_DONE;
          end
        end
        S_ERR: begin
          if (hready) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          err_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_line_fill_ctrl.sv
// Testbench for ahb_line_fill_ctrl: a 4-word and an 8-word instance share the
// clock, reset and AHB handshake inputs; each has its own miss_req and its own
// read-data slave. A transaction-level model derives every expected output
// from the line base and the bus handshakes; directed tests add literal
// expectations on addresses, beat counts and cycle latencies.
`timescale 1ns/1ps
module tb_ahb_line_fill_ctrl;

  logic        clk;
  logic        rst;
  logic        miss_req4, miss_req8;
  logic [31:0] miss_addr;
  logic        hready, hresp;

  logic        fill_busy4, fill_we4, fill_done4, fill_err4, hwrite4;
  logic [1:0]  fill_idx4, htrans4;
  logic [31:0] fill_data4, haddr4, hrdata4;
  logic [2:0]  hburst4, hsize4;

  logic        fill_busy8, fill_we8, fill_done8, fill_err8, hwrite8;
  logic [2:0]  fill_idx8;
  logic [1:0]  htrans8;
  logic [31:0] fill_data8, haddr8, hrdata8;
  logic [2:0]  hburst8, hsize8;

  ahb_line_fill_ctrl #(.LINE_WORDS(4)) u_dut4 (
    .clk(clk), .rst(rst), .miss_req(miss_req4), .miss_addr(miss_addr),
    .fill_busy(fill_busy4), .fill_we(fill_we4), .fill_idx(fill_idx4),
    .fill_data(fill_data4), .fill_done(fill_done4), .fill_err(fill_err4),
    .haddr(haddr4), .htrans(htrans4), .hburst(hburst4), .hsize(hsize4),
    .hwrite(hwrite4), .hready(hready), .hrdata(hrdata4), .hresp(hresp)
  );

  ahb_line_fill_ctrl #(.LINE_WORDS(8)) u_dut8 (
    .clk(clk), .rst(rst), .miss_req(miss_req8), .miss_addr(miss_addr),
    .fill_busy(fill_busy8), .fill_we(fill_we8), .fill_idx(fill_idx8),
    .fill_data(fill_data8), .fill_done(fill_done8), .fill_err(fill_err8),
    .haddr(haddr8), .htrans(htrans8), .hburst(hburst8), .hsize(hsize8),
    .hwrite(hwrite8), .hready(hready), .hrdata(hrdata8), .hresp(hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 60) $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Word the slave returns for a given address (distinct per instance).
  function automatic logic [31:0] fdata(input int id, input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ ((id == 0) ? 32'h0000_0000 : 32'h0F0F_0F0F);
  endfunction

  // Simple AHB read slave per instance: remembers the accepted address and
  // returns its data word during the following data phase.
  logic [31:0] s_addr4, s_addr8;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_addr4 <= '0;
      s_addr8 <= '0;
    end else begin
      if (htrans4[1] && hready) s_addr4 <= haddr4;
      if (htrans8[1] && hready) s_addr8 <= haddr8;
    end
  end
  assign hrdata4 = fdata(0, s_addr4);
  assign hrdata8 = fdata(1, s_addr8);

  // Per-instance views for the compare process.
  logic        busy_a[2], we_a[2], done_a[2], err_a[2], hwrite_a[2], miss_a[2];
  logic [1:0]  htrans_a[2];
  logic [2:0]  hburst_a[2], hsize_a[2];
  logic [3:0]  idx_a[2];
  logic [31:0] haddr_a[2], data_a[2];
  assign busy_a[0] = fill_busy4;  assign busy_a[1] = fill_busy8;
  assign we_a[0]   = fill_we4;    assign we_a[1]   = fill_we8;
  assign done_a[0] = fill_done4;  assign done_a[1] = fill_done8;
  assign err_a[0]  = fill_err4;   assign err_a[1]  = fill_err8;
  assign hwrite_a[0] = hwrite4;   assign hwrite_a[1] = hwrite8;
  assign miss_a[0] = miss_req4;   assign miss_a[1] = miss_req8;
  assign htrans_a[0] = htrans4;   assign htrans_a[1] = htrans8;
  assign hburst_a[0] = hburst4;   assign hburst_a[1] = hburst8;
  assign hsize_a[0] = hsize4;     assign hsize_a[1] = hsize8;
  assign idx_a[0] = {2'b00, fill_idx4};
  assign idx_a[1] = {1'b0, fill_idx8};
  assign haddr_a[0] = haddr4;     assign haddr_a[1] = haddr8;
  assign data_a[0] = fill_data4;  assign data_a[1] = fill_data8;

  // Transaction-level model state.
  bit          m_active[2], m_dph[2], m_err[2], m_done_due[2];
  int          m_acnt[2], m_wcnt[2];
  logic [31:0] m_base[2];

  // Observation logs used by the directed tests.
  logic [31:0] acc_q4[$];
  logic [31:0] acc_q8[$];
  int start_cyc[2], nonseq_cyc[2], first_we_cyc[2], we_count[2];
  int done_cyc[2], dut_done_cnt[2];
  bit done_err_log[2];

  int          lw_m;
  bit          err_now, exp_we, complete, next_done;
  logic [1:0]  exp_tr;
  logic [2:0]  exp_burst;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      lw_m = (i == 0) ? 4 : 8;
      exp_burst = (i == 0) ? 3'b011 : 3'b101;
      if (rst) begin
        check("rst_busy", busy_a[i], 1'b0);
        check("rst_htrans", htrans_a[i], 2'b00);
        check("rst_done", done_a[i], 1'b0);
        check("rst_we", we_a[i], 1'b0);
        m_active[i] = 0; m_dph[i] = 0; m_err[i] = 0; m_done_due[i] = 0;
        m_acnt[i] = 0; m_wcnt[i] = 0;
      end else begin
        check("hsize", hsize_a[i], 3'b010);
        check("hwrite", hwrite_a[i], 1'b0);
        check("hburst", hburst_a[i], exp_burst);
        check("busy", busy_a[i], m_active[i]);

        err_now = m_active[i] && m_dph[i] && hresp && !hready;
        if (m_active[i] && !m_err[i] && !err_now && !m_done_due[i] && m_acnt[i] < lw_m)
          exp_tr = (m_acnt[i] == 0) ? 2'b10 : 2'b11;
        else
          exp_tr = 2'b00;
        check("htrans", htrans_a[i], exp_tr);
        if (exp_tr != 2'b00) check("haddr", haddr_a[i], m_base[i] + 32'(4 * m_acnt[i]));

        exp_we = m_active[i] && m_dph[i] && hready && !hresp && !m_err[i];
        check("fill_we", we_a[i], exp_we);
        if (exp_we) begin
          check("fill_idx", idx_a[i], 4'(m_wcnt[i]));
          check("fill_data", data_a[i], fdata(i, m_base[i] + 32'(4 * m_wcnt[i])));
        end
        check("fill_done", done_a[i], m_done_due[i]);
        check("fill_err", err_a[i], m_done_due[i] && m_err[i]);

        // logs of what the DUT actually did
        if (exp_we && we_a[i]) begin
          if (we_count[i] == 0) first_we_cyc[i] = cyc;
          we_count[i]++;
        end
        if (done_a[i]) begin
          dut_done_cnt[i]++;
          done_cyc[i] = cyc;
          done_err_log[i] = err_a[i];
        end
        if (htrans_a[i] == 2'b10 && nonseq_cyc[i] < 0) nonseq_cyc[i] = cyc;

        // advance the model
        if (!m_active[i]) begin
          if (miss_a[i]) begin
            m_active[i] = 1;
            m_base[i] = miss_addr & ~32'(lw_m * 4 - 1);
            m_acnt[i] = 0; m_wcnt[i] = 0; m_dph[i] = 0; m_err[i] = 0;
            start_cyc[i] = cyc; nonseq_cyc[i] = -1; we_count[i] = 0; first_we_cyc[i] = -1;
            if (i == 0) acc_q4.delete(); else acc_q8.delete();
          end
        end else if (m_done_due[i]) begin
          m_active[i] = 0;
          m_done_due[i] = 0;
          m_err[i] = 0;
        end else begin
          next_done = 0;
          complete = m_dph[i] && hready;
          if (err_now) m_err[i] = 1;
          if (complete) begin
            if (m_err[i]) next_done = 1;
            else if (hresp) m_err[i] = 1;
            else begin
              m_wcnt[i]++;
              if (m_wcnt[i] == lw_m) next_done = 1;
            end
          end
          if (exp_tr != 2'b00 && hready) begin
            if (i == 0) acc_q4.push_back(haddr_a[i]); else acc_q8.push_back(haddr_a[i]);
            m_acnt[i]++;
            m_dph[i] = 1;
          end else if (complete) begin
            m_dph[i] = 0;
          end
          m_done_due[i] = next_done;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int id, input int budget);
    int c0;
    int n;
    c0 = dut_done_cnt[id];
    n = 0;
    while (dut_done_cnt[id] == c0 && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", dut_done_cnt[id] != c0, 1'b1);
    tick();
  endtask

  int t0, d1, c_before;

  initial begin
    rst = 1'b1; miss_req4 = 1'b0; miss_req8 = 1'b0; miss_addr = '0;
    hready = 1'b1; hresp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_cyc[i] = 0; nonseq_cyc[i] = -1; first_we_cyc[i] = -1;
      we_count[i] = 0; done_cyc[i] = 0; dut_done_cnt[i] = 0; done_err_log[i] = 0;
    end
    tick(); tick();
    check("reset_haddr4", haddr4, 32'h0);
    check("reset_haddr8", haddr8, 32'h0);
    check("reset_busy4", fill_busy4, 1'b0);
    rst = 1'b0;
    tick();

    // 1: zero-wait fill of line 0x1230
    miss_req4 = 1'b1; miss_addr = 32'h0000_1234; t0 = cyc;
    tick(); miss_req4 = 1'b0;
    wait_done(0, 40);
    check("t1_beats", acc_q4.size(), 4);
    if (acc_q4.size() == 4) begin
      check("t1_addr0", acc_q4[0], 32'h0000_1230);
      check("t1_addr1", acc_q4[1], 32'h0000_1234);
      check("t1_addr2", acc_q4[2], 32'h0000_1238);
      check("t1_addr3", acc_q4[3], 32'h0000_123C);
    end
    check("t1_nonseq_lat", nonseq_cyc[0] - t0, 1);
    check("t1_first_we_lat", first_we_cyc[0] - t0, 2);
    check("t1_we_count", we_count[0], 4);
    check("t1_done_lat", done_cyc[0] - t0, 6);
    check("t1_done_err", done_err_log[0], 1'b0);
    check("t1_hburst4", hburst4, 3'b011);

    // 2: two wait states in beat-1 data phase
    miss_req4 = 1'b1; miss_addr = 32'h0000_1234; t0 = cyc;
    tick(); miss_req4 = 1'b0;
    tick();
    tick(); hready = 1'b0;
    @(negedge clk);
    check("t2_stall_haddr_a", haddr4, 32'h0000_1238);
    check("t2_stall_htrans_a", htrans4, 2'b11);
    tick(); hready = 1'b0;
    @(negedge clk);
    check("t2_stall_haddr_b", haddr4, 32'h0000_1238);
    check("t2_stall_we", fill_we4, 1'b0);
    tick(); hready = 1'b1;
    wait_done(0, 40);
    check("t2_we_count", we_count[0], 4);
    check("t2_done_lat", done_cyc[0] - t0, 8);

    // 3: ERROR response on beat 2
    miss_req4 = 1'b1; miss_addr = 32'h0000_1234; t0 = cyc;
    tick(); miss_req4 = 1'b0;
    tick();
    tick();
    tick(); hresp = 1'b1; hready = 1'b0;
    @(negedge clk);
    check("t3_err_htrans", htrans4, 2'b00);
    tick(); hready = 1'b1;
    tick(); hresp = 1'b0;
    wait_done(0, 40);
    check("t3_we_count", we_count[0], 2);
    check("t3_done_lat", done_cyc[0] - t0, 6);
    check("t3_done_err", done_err_log[0], 1'b1);

    // 4: miss_req held high with a new address during the fill
    miss_req4 = 1'b1; miss_addr = 32'h0000_1234; t0 = cyc;
    tick(); miss_addr = 32'h0000_5678;
    wait_done(0, 40);
    d1 = done_cyc[0];
    miss_req4 = 1'b0;
    wait_done(0, 40);
    check("t4_restart_cyc", start_cyc[0] - d1, 1);
    check("t4_nonseq_cyc", nonseq_cyc[0] - d1, 2);
    check("t4_beats", acc_q4.size(), 4);
    if (acc_q4.size() == 4) begin
      check("t4_addr0", acc_q4[0], 32'h0000_5670);
      check("t4_addr3", acc_q4[3], 32'h0000_567C);
    end

    // 5: reset during the beat-2 address phase
    miss_req4 = 1'b1; miss_addr = 32'h0000_1234; t0 = cyc;
    tick(); miss_req4 = 1'b0;
    tick();
    tick();
    check("t5_pre_rst_htrans", htrans4, 2'b11);
    check("t5_pre_rst_haddr", haddr4, 32'h0000_1238);
    c_before = dut_done_cnt[0];
    rst = 1'b1;
    #1;
    check("t5_rst_htrans", htrans4, 2'b00);
    check("t5_rst_busy", fill_busy4, 1'b0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("t5_no_done", dut_done_cnt[0], c_before);
    miss_req4 = 1'b1; miss_addr = 32'h0000_2000; t0 = cyc;
    tick(); miss_req4 = 1'b0;
    wait_done(0, 40);
    check("t5_nonseq_lat", nonseq_cyc[0] - t0, 1);
    check("t5_done_lat", done_cyc[0] - t0, 6);
    check("t5_beats", acc_q4.size(), 4);
    if (acc_q4.size() == 4) check("t5_addr0", acc_q4[0], 32'h0000_2000);

    // 6: 8-word line, unaligned miss address inside line 0x8000_0000
    miss_req8 = 1'b1; miss_addr = 32'h8000_0014; t0 = cyc;
    tick(); miss_req8 = 1'b0;
    wait_done(1, 60);
    check("t6_hburst8", hburst8, 3'b101);
    check("t6_beats", acc_q8.size(), 8);
    if (acc_q8.size() == 8) begin
      check("t6_addr0", acc_q8[0], 32'h8000_0000);
      check("t6_addr7", acc_q8[7], 32'h8000_001C);
    end
    check("t6_we_count", we_count[1], 8);
    check("t6_first_we_lat", first_we_cyc[1] - t0, 2);
    check("t6_done_lat", done_cyc[1] - t0, 10);
    check("t6_done_err", done_err_log[1], 1'b0);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
